// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit period.
package uart_rx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10417;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the raw serial line plus a registered falling-edge detector.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] sync_reg;
  logic              fall_reg;

  // Flops reset to 1 so a released reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], rx};
      fall_reg <= sync_reg[STAGES-1] & ~sync_reg[STAGES-2];
    end
  end

  assign rx_s = sync_reg[STAGES-1];
  assign fall = fall_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, LSB-first data, stop-bit check.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic          rx_s;
  logic          fall;
  rx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          err_reg;
  logic          busy_reg;

  rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fall) begin
            state_reg <= START;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg <= DATA;
              idx_reg   <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rx_s;
            idx_reg            <= idx_reg + 3'd1;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        // Line stuck low after a bad stop bit: wait for idle before re-arming.
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign recv_data  = data_reg;
  assign recv_valid = valid_reg;
  assign frame_err  = err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames followed by randomized frames vs. a frame-level model.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .recv_data  (recv_data),
    .recv_valid (recv_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int   cyc = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   viol_cnt = 0;
  int   last_valid_cyc = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts output pulses and flags overlapping or stretched pulses.
  always @(negedge clk) begin
    if (recv_valid === 1'b1) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if ((recv_valid && frame_err) || ((recv_valid || frame_err) && prev_pulse))
      viol_cnt <= viol_cnt + 1;
    prev_pulse <= recv_valid | frame_err;
  end

  int passed = 0;
  int total  = 0;

  int         exp_valid = 0;
  int         exp_err   = 0;
  logic [7:0] exp_data  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop_bit, CPB);
  endtask

  // Reference: a good stop bit yields the byte, a bad one yields an error and keeps old data.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit);
    if (stop_bit) begin
      exp_valid++;
      exp_data = d;
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_data"}, {24'd0, recv_data}, {24'd0, exp_data});
  endtask

  initial begin
    int         start_cyc;
    int         lat;
    logic [7:0] d;
    logic       good;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data", {24'd0, recv_data}, 32'h0);
    check("reset_valid", {31'd0, recv_valid}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single good frame with latency measurement
    start_cyc = cyc;
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    check_counts("f55");
    check("f55_busy_after", {31'd0, busy}, 32'd0);
    lat = last_valid_cyc - start_cyc;
    check("f55_latency_in_window", {31'd0, (lat >= 155 && lat <= 157)}, 32'd1);
    drive(1'b1, 8);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1);
    model_frame(8'hA3, 1'b1);
    check_counts("fA3");
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1);
    check_counts("f0F");
    drive(1'b1, 8);

    // Short low glitch must be rejected in START
    drive(1'b0, 3);
    drive(1'b1, 30);
    check_counts("glitch");
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Bad stop bit, line held low afterwards
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    drive(1'b0, 40);
    check_counts("f3C_bad_stop");
    check("f3C_busy_while_low", {31'd0, busy}, 32'd1);
    drive(1'b1, 5);
    check("f3C_busy_after_high", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 4 of 0xFF
    drive(1'b0, CPB);
    drive(1'b1, 4 * CPB + 8);
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    exp_data = 8'h00;
    check("rst_mid_data", {24'd0, recv_data}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 4 * CPB);
    check_counts("rst_abort");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    check_counts("f81");
    drive(1'b1, 4);

    // Randomized frames with random stop-bit quality and gaps
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good);
      model_frame(d, good);
      if (!good) drive(1'b0, $urandom_range(5, 30));
      check_counts($sformatf("rnd%0d", n));
      drive(1'b1, good ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end

    drive(1'b1, 8);
    check("final_busy", {31'd0, busy}, 32'd0);
    check("pulse_protocol_violations", viol_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
